char_pixel_streamer: RTL and testbench
======================================

Name: char_pixel_streamer

Overview:
- Reader side of the 5x7 character ROM.
- Accepts one 7-bit ASCII code per handshake and drives the ROM address.
- Captures the 35-bit glyph bitmap, then streams it one pixel per valid/ready beat, column-major, followed by blank gap columns.
- Sits between the text/scroll controller and the WS2812B pixel driver.

Parameters:
- CHAR_W, 5, glyph width in columns.
- CHAR_H, 7, glyph height in rows.
- GAP_COLS, 1, all-zero columns appended after each glyph (0 allowed).
- DATA_WIDTH, 35, ROM word width; must equal CHAR_W*CHAR_H.
- ADDR_WIDTH, 7, character code / ROM address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- char_in  in  ADDR_WIDTH  character code to render.
- char_valid  in  1  char_in valid.
- char_ready  out  1  block can accept a character.
- rom_addr  out  ADDR_WIDTH  address to character ROM (registered).
- rom_data  in  DATA_WIDTH  glyph bitmap from ROM, combinational on rom_addr.
- pix_out  out  1  current pixel value (1 = lit).
- pix_row  out  $clog2(CHAR_H)  row of current pixel, 0 = top.
- pix_col  out  $clog2(CHAR_W+GAP_COLS)  column of current pixel, 0 = left.
- pix_last  out  1  current beat is the final pixel of this character.
- pix_valid  out  1  pixel outputs valid.
- pix_ready  in  1  consumer accepts pixel.

Behaviour:
- One clock, asynchronous active-high reset. On rst: state=IDLE; rom_addr=0; bitmap register=0; row=col=0; pix_valid=0; pix_out=0; pix_last=0. Reset wins over any handshake.
- Bitmap bit order: pixel (r,c) = rom_data[DATA_WIDTH-1 - (r*CHAR_W + c)], i.e. row-major, MSB = top-left.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - char_ready=1 (combinational from state); all other outputs 0.
  - On char_valid&&char_ready: rom_addr<=char_in, go to LOAD.
- LOAD (exactly 1 cycle):
  - char_ready=0, pix_valid=0.
  - Capture rom_data into bitmap register; row<=0, col<=0; go to STREAM.
- STREAM:
  - pix_valid=1, char_ready=0.
  - pix_out = bitmap pixel (row,col) when col<CHAR_W, else 0 (gap column).
  - pix_row/pix_col reflect the counters.
  - On pix_valid&&pix_ready:
    - row<CHAR_H-1: row++.
    - Otherwise row<=0, col++.
  - pix_last=1 only when row=CHAR_H-1 and col=CHAR_W+GAP_COLS-1.
  - When the pix_last beat is accepted, go to IDLE.
- Latency: char accepted at cycle N; rom_addr valid N+1; first pix_valid at N+2.
- Beats per character: (CHAR_W+GAP_COLS)*CHAR_H (42 at defaults).
- Minimum period: beats+2 cycles. char_ready rises the cycle after the pix_last acceptance; there is no overlap between characters.
- Backpressure: while pix_valid && !pix_ready, all pixel outputs and counters hold stable.
- Codes below 32: the ROM returns 0, so a blank glyph is streamed normally with the full beat count.
- rom_addr holds its last value after the stream; the ROM output is only sampled in LOAD.
- Reset mid-operation: pix_valid drops asynchronously; the next character after release starts at row 0, col 0.
- pix_ready while pix_valid=0 is ignored. char_valid outside IDLE is ignored; the producer holds it.

Test Plan:
- Bench ROM model: rom_data = distinct per-address pattern, e.g. {address, 28'hA5C3_96F}.
- Reset: assert rst mid-clock -> pix_valid=0, rom_addr=0, char_ready=1 immediately; all held through release.
- Single char 0x41, pix_ready=1:
  - rom_addr=0x41 at N+1; pix_valid rises N+2.
  - Exactly 42 beats with pix_out matching the bit formula column-major.
  - Beats 36-42 (col 5) have pix_out=0; pix_last only on beat 42.
  - char_ready=1 at N+44.
- Backpressure: same char with pix_ready randomly low (~50%) -> beat sequence identical to the previous test; outputs unchanged on every stalled cycle.
- Control code 0x05 -> 42 beats, all pix_out=0, pix_last on beat 42.
- Reset at beat 10 -> pix_valid=0 asynchronously. After release, char 0x42 streams from (row0,col0) with the full 42 beats.
- Back-to-back: char_valid held high with 0x30 then 0x31 -> second accepted the cycle after the first pix_last beat. char_ready=0 throughout LOAD/STREAM; GAP_COLS=0 build yields 35 beats per char.

Source files
------------

// File: rtl/char_pixel_streamer.sv
// Character ROM reader: fetches a 5x7 glyph per accepted code and
// streams it column-major as one pixel per valid/ready beat, plus gap columns.
module char_pixel_streamer #(
  parameter int CHAR_W     = 5,
  parameter int CHAR_H     = 7,
  parameter int GAP_COLS   = 1,
  parameter int DATA_WIDTH = 35,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  pix_out,
  output logic [((CHAR_H > 1) ? $clog2(CHAR_H) : 1)-1:0] pix_row,
  output logic [((CHAR_W + GAP_COLS > 1) ? $clog2(CHAR_W + GAP_COLS) : 1)-1:0] pix_col,
  output logic                  pix_last,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int COLS = CHAR_W + GAP_COLS;
  localparam int RW   = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_MAX = RW'(CHAR_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [DATA_WIDTH-1:0]   bitmap;
  logic [DATA_WIDTH-1:0]   shifted;
  logic                    row_end;
  logic                    at_last;
  int                      lin;

  assign row_end = (row == ROW_MAX);
  assign at_last = row_end && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    char_ready = 1'b0;
    pix_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = STREAM;
      end
      STREAM: begin
        pix_valid = 1'b1;
        if (pix_ready && at_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      bitmap   <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      if (state == IDLE && char_valid) begin
        rom_addr <= char_in;
      end
      if (state == LOAD) begin
        bitmap <= rom_data;
        row    <= '0;
        col    <= '0;
      end
      if (state == STREAM && pix_ready) begin
        if (at_last) begin
          row <= '0;
          col <= '0;
        end else if (row_end) begin
          row <= '0;
          col <= col + CW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end
    end
  end

  // Bitmap is row-major with MSB at top-left; shift the wanted bit to the MSB.
  always_comb begin
    lin     = int'(row) * CHAR_W + int'(col);
    shifted = bitmap << lin;
    pix_out = pix_valid && (int'(col) < CHAR_W) && shifted[DATA_WIDTH-1];
  end

  assign pix_last = pix_valid && at_last;
  assign pix_row  = pix_valid ? row : '0;
  assign pix_col  = pix_valid ? col : '0;

endmodule

// File: tb/tb_char_pixel_streamer.sv
// Bench for char_pixel_streamer: ROM model, glyph pixel model, directed and
// random characters on a GAP_COLS=1 and a GAP_COLS=0 instance.
module tb_char_pixel_streamer;

  localparam int CW = 5;
  localparam int CH = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  char_in = '0;
  logic        char_valid = 1'b0;
  logic        pix_ready = 1'b0;
  logic        sel = 1'b0;

  logic        cr1, pv1, po1, pl1;
  logic [6:0]  ra1;
  logic [34:0] rd1;
  logic [2:0]  pr1, pc1;
  logic        cr0, pv0, po0, pl0;
  logic [6:0]  ra0;
  logic [34:0] rd0;
  logic [2:0]  pr0, pc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [34:0] rom_model(input logic [6:0] a);
    if (a < 7'd32) return '0;
    return {a, 28'hA5C396F};
  endfunction

  function automatic logic model_pix(input logic [6:0] a, input int r,
                                     input int c);
    logic [34:0] w;
    if (c >= CW) return 1'b0;
    w = rom_model(a);
    w = w << (r * CW + c);
    return w[34];
  endfunction

  assign rd1 = rom_model(ra1);
  assign rd0 = rom_model(ra0);

  char_pixel_streamer #(.GAP_COLS(1)) dut (
    .clk(clk), .rst(rst), .char_in(char_in),
    .char_valid(char_valid & ~sel), .char_ready(cr1),
    .rom_addr(ra1), .rom_data(rd1), .pix_out(po1), .pix_row(pr1),
    .pix_col(pc1), .pix_last(pl1), .pix_valid(pv1), .pix_ready(pix_ready)
  );

  char_pixel_streamer #(.GAP_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .char_in(char_in),
    .char_valid(char_valid & sel), .char_ready(cr0),
    .rom_addr(ra0), .rom_data(rd0), .pix_out(po0), .pix_row(pr0),
    .pix_col(pc0), .pix_last(pl0), .pix_valid(pv0), .pix_ready(pix_ready)
  );

  logic       o_cr, o_pv, o_po, o_pl;
  logic [6:0] o_ra;
  logic [2:0] o_pr, o_pc;
  assign o_cr = sel ? cr0 : cr1;
  assign o_pv = sel ? pv0 : pv1;
  assign o_po = sel ? po0 : po1;
  assign o_pl = sel ? pl0 : pl1;
  assign o_ra = sel ? ra0 : ra1;
  assign o_pr = sel ? pr0 : pr1;
  assign o_pc = sel ? pc0 : pc1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one character and follow its stream beat by beat.
  task automatic run_char(input bit s, input logic [6:0] code,
                          input bit stall, input int abort_at,
                          input bit hold, input logic [6:0] nxt);
    int total, beat, cyc, r, c;
    bit stalled;
    logic [7:0] prev;
    total = (s ? CW : CW + 1) * CH;
    sel = s;
    chk("ready_idle", o_cr, 1);
    char_in = code;
    char_valid = 1'b1;
    @(negedge clk);
    chk("rom_addr_n1", o_ra, code);
    chk("load_valid", o_pv, 0);
    chk("load_ready", o_cr, 0);
    if (!hold) char_valid = 1'b0;
    @(negedge clk);
    chk("valid_n2", o_pv, 1);
    beat = 0;
    cyc = 0;
    stalled = 0;
    prev = '0;
    while (beat < total && cyc < 2000) begin
      if (beat == abort_at) return;
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      r = beat % CH;
      c = beat / CH;
      chk("valid", o_pv, 1);
      chk("busy", o_cr, 0);
      chk("pix_out", o_po, model_pix(code, r, c));
      chk("pix_row", o_pr, r);
      chk("pix_col", o_pc, c);
      chk("pix_last", o_pl, beat == total - 1);
      if (stalled) chk("stall_hold", {o_po, o_pr, o_pc, o_pl}, prev);
      prev = {o_po, o_pr, o_pc, o_pl};
      stalled = !pix_ready;
      if (hold && beat == total - 1 && pix_ready) char_in = nxt;
      if (pix_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    chk("beats", beat, total);
    if (!stall) chk("cycles", cyc, total);
    chk("ready_after", o_cr, 1);
    chk("valid_after", o_pv, 0);
    pix_ready = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", pv1, 0);
    chk("rst_addr", ra1, 0);
    chk("rst_ready", cr1, 1);
    chk("rst_ready0", cr0, 1);
    char_valid = 1'b1;
    char_in = 7'h41;
    pix_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", pv1, 0);
      chk("rst_hold_addr", ra1, 0);
      chk("rst_hold_ready", cr1, 1);
    end
    char_valid = 1'b0;
    pix_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_char(0, 7'h41, 0, -1, 0, 7'h00);
    run_char(0, 7'h41, 1, -1, 0, 7'h00);
    run_char(0, 7'h05, 0, -1, 0, 7'h00);

    run_char(0, 7'h41, 0, 10, 0, 7'h00);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", pv1, 0);
    chk("mid_rst_ready", cr1, 1);
    chk("mid_rst_addr", ra1, 0);
    pix_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_char(0, 7'h42, 0, -1, 0, 7'h00);

    run_char(0, 7'h30, 0, -1, 1, 7'h31);
    run_char(0, 7'h31, 0, -1, 0, 7'h00);

    run_char(1, 7'h41, 0, -1, 0, 7'h00);
    run_char(1, 7'h5A, 1, -1, 0, 7'h00);

    for (int i = 0; i < 4; i++) begin
      run_char(0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
               -1, 0, 7'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
